// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

    // Frame format defaults shared by the transmitter and receiver.
    localparam int DEFAULT_DATA_LENGTH  = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - serial line and word handshake bundle for the UART receiver
interface uart_receiver_if
    import uart_pkg::*;
#(
    parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH
);
    logic                   serialdata_in;
    logic                   parity_type;
    logic                   rx_ack;
    logic [DATA_LENGTH-1:0] dataout;
    logic                   rx_valid;
    logic                   rx_busy;
    logic                   frame_err;
    logic                   parity_err;
    logic                   overrun_err;

    // Receiver side.
    modport master (
        input  serialdata_in, parity_type, rx_ack,
        output dataout, rx_valid, rx_busy, frame_err, parity_err, overrun_err
    );

    // Line driver and word consumer side.
    modport slave (
        output serialdata_in, parity_type, rx_ack,
        input  dataout, rx_valid, rx_busy, frame_err, parity_err, overrun_err
    );
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the asynchronous serial line
module uart_rx_sync (
    input  logic rx_clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    // Both flops reset to the idle-high line level so no false start follows reset.
    always_ff @(posedge rx_clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receiver with sticky error flags; UART_RX_PARITY_EN adds a parity bit
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_LENGTH  = DEFAULT_DATA_LENGTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic            rx_clk,
    input  logic            rst,
    uart_receiver_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_LENGTH + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_LENGTH - 1);

    logic                   line_sync;
    logic                   line_prev;
    rx_state_t              state;
    logic [CW-1:0]          bit_cnt;
    logic [BW-1:0]          data_cnt;
    logic [DATA_LENGTH-1:0] shreg;
    logic                   deliver;
    logic [DATA_LENGTH-1:0] dataout_q;
    logic                   rx_valid_q;
    logic                   rx_busy_q;
    logic                   frame_err_q;
    logic                   overrun_err_q;
    logic                   mid_bit;
    logic [CW-1:0]          bit_cnt_next;
`ifdef UART_RX_PARITY_EN
    logic                   par_pend;
    logic                   parity_err_q;
`endif

    uart_rx_sync u_sync (
        .rx_clk (rx_clk),
        .rst    (rst),
        .d      (bus.serialdata_in),
        .q      (line_sync)
    );

    // Mid-bit strobe and free-running wrap of the per-bit clock counter.
    assign mid_bit      = (bit_cnt == FULL_LAST);
    assign bit_cnt_next = mid_bit ? '0 : bit_cnt + 1'b1;

    assign bus.dataout     = dataout_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_busy     = rx_busy_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err  = parity_err_q;
`else
    assign bus.parity_err  = 1'b0;
`endif

    // Frame FSM, word delivery and sticky flags; later assignments take priority over the ack clear.
    always_ff @(posedge rx_clk or negedge rst) begin
        if (!rst) begin
            line_prev     <= 1'b1;
            state         <= IDLE;
            bit_cnt       <= '0;
            data_cnt      <= '0;
            shreg         <= '0;
            deliver       <= 1'b0;
            dataout_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_busy_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_pend      <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            line_prev <= line_sync;
            deliver   <= 1'b0;

            if (bus.rx_ack && rx_valid_q) begin
                rx_valid_q    <= 1'b0;
                frame_err_q   <= 1'b0;
                overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q  <= 1'b0;
`endif
            end

            // A word acked in this same cycle frees the holding register for the new one.
            if (deliver) begin
                if (!rx_valid_q || bus.rx_ack) begin
                    dataout_q  <= shreg;
                    rx_valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (par_pend)
                        parity_err_q <= 1'b1;
`endif
                end else begin
                    overrun_err_q <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (line_prev && !line_sync) begin
                        state     <= START;
                        rx_busy_q <= 1'b1;
                        bit_cnt   <= '0;
                        data_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
                        par_pend  <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        if (line_sync) begin
                            state     <= IDLE;
                            rx_busy_q <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    bit_cnt <= bit_cnt_next;
                    if (mid_bit) begin
                        shreg <= {line_sync, shreg[DATA_LENGTH-1:1]};
                        if (data_cnt == BITS_LAST) begin
                            data_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state    <= PARITY;
`else
                            state    <= STOP;
`endif
                        end else begin
                            data_cnt <= data_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    bit_cnt <= bit_cnt_next;
                    if (mid_bit) begin
`ifdef UART_RX_PARITY_EN
                        if (line_sync != (bus.parity_type ? ~^shreg : ^shreg))
                            par_pend <= 1'b1;
`endif
                        state <= STOP;
                    end
                end
                STOP: begin
                    bit_cnt <= bit_cnt_next;
                    if (mid_bit) begin
                        deliver <= 1'b1;
                        if (line_sync) begin
                            state     <= IDLE;
                            rx_busy_q <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (line_sync) begin
                        state     <= IDLE;
                        rx_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver with a frame-level reference model
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int DL  = 8;
    localparam int CPB = 16;

    typedef struct packed {
        logic [DL-1:0] data;
        logic          ferr;
        logic          perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   auto_ack = 1'b1;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    uart_receiver_if #(.DATA_LENGTH(DL)) bus ();

    uart_receiver #(
        .DATA_LENGTH  (DL),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .rx_clk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Expected word from the frame as transmitted: the data itself, a bad stop bit, a wrong parity bit.
    function automatic exp_t model(input logic [DL-1:0] d, input logic stop, input logic pt, input logic pb);
        exp_t e;
        e.data = d;
        e.ferr = (stop == 1'b0);
`ifdef UART_RX_PARITY_EN
        e.perr = (pb != logic'(($countones(d) + int'(pt)) % 2));
`else
        e.perr = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic good_parity(input logic [DL-1:0] d, input logic pt);
        return logic'(($countones(d) + int'(pt)) % 2);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bus.serialdata_in = b;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [DL-1:0] d, input logic stop, input logic pb);
        drive_bit(1'b0);
        for (int i = 0; i < DL; i++)
            drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(pb);
`endif
        drive_bit(stop);
    endtask

    task automatic expect_frame(input logic [DL-1:0] d, input logic stop, input logic pb);
        sb.push_back(model(d, stop, bus.parity_type, pb));
        send_frame(d, stop, pb);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000 && sb.size() != 0; i++)
            idle(1);
        check(name, sb.size(), 0);
    endtask

    // Monitor: every presented word is popped from the scoreboard, compared, then acked.
    initial begin
        bus.rx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && auto_ack && bus.rx_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h with nothing expected", bus.dataout);
                end else begin
                    mon_e = sb.pop_front();
                    check("word_data", bus.dataout, mon_e.data);
                    check("word_frame_err", bus.frame_err, mon_e.ferr);
                    check("word_parity_err", bus.parity_err, mon_e.perr);
                    check("word_overrun_err", bus.overrun_err, 0);
                end
                bus.rx_ack = 1'b1;
                @(negedge clk);
                bus.rx_ack = 1'b0;
            end
        end
    end

    initial begin
        logic [DL-1:0] d;
        logic          stop;
        logic          pb;

        bus.serialdata_in = 1'b1;
        bus.parity_type   = 1'b0;
        rst = 1'b0;
        idle(3);
        check("rst_dataout", bus.dataout, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_busy", bus.rx_busy, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_parity_err", bus.parity_err, 0);
        check("rst_overrun_err", bus.overrun_err, 0);
        rst = 1'b1;
        idle(5);

        // Clean frame.
        expect_frame(8'hA5, 1'b1, good_parity(8'hA5, 1'b0));
        idle(20);
        drain("clean_drained");

        // Four-cycle glitch must be rejected as a false start.
        bus.serialdata_in = 1'b0;
        idle(4);
        bus.serialdata_in = 1'b1;
        idle(30);
        check("glitch_busy", bus.rx_busy, 0);
        check("glitch_valid", bus.rx_valid, 0);

        // Bad stop bit: word still delivered, receiver parked until the line goes high.
        expect_frame(8'h3C, 1'b0, good_parity(8'h3C, 1'b0));
        idle(2 * CPB);
        check("wait_idle_busy", bus.rx_busy, 1);
        bus.serialdata_in = 1'b1;
        idle(5);
        check("wait_idle_exit", bus.rx_busy, 0);
        drain("badstop_drained");

`ifdef UART_RX_PARITY_EN
        bus.parity_type = 1'b0;
        expect_frame(8'h07, 1'b1, 1'b0);
        idle(8);
        expect_frame(8'h07, 1'b1, 1'b1);
        idle(8);
        drain("parity_drained");
`endif

        // Randomized frames.
        for (int n = 0; n < 12; n++) begin
            d    = DL'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            bus.parity_type = 1'($urandom_range(0, 1));
            pb   = ($urandom_range(0, 2) == 0) ? ~good_parity(d, bus.parity_type)
                                               : good_parity(d, bus.parity_type);
            expect_frame(d, stop, pb);
            if (!stop) begin
                idle(CPB);
                bus.serialdata_in = 1'b1;
            end
            idle($urandom_range(4, 20));
        end
        drain("random_drained");

        // Overrun: second word arrives while the first is still unacknowledged.
        auto_ack = 1'b0;
        bus.parity_type = 1'b0;
        send_frame(8'h11, 1'b1, good_parity(8'h11, 1'b0));
        send_frame(8'h22, 1'b1, good_parity(8'h22, 1'b0));
        idle(5);
        check("ovr_dataout", bus.dataout, 8'h11);
        check("ovr_valid", bus.rx_valid, 1);
        check("ovr_overrun", bus.overrun_err, 1);
        check("ovr_frame_err", bus.frame_err, 0);
        bus.rx_ack = 1'b1;
        idle(1);
        bus.rx_ack = 1'b0;
        check("ack_valid", bus.rx_valid, 0);
        check("ack_overrun", bus.overrun_err, 0);
        check("ack_frame_err", bus.frame_err, 0);
        check("ack_parity_err", bus.parity_err, 0);
        auto_ack = 1'b1;
        idle(4);

        // Reset in the middle of data bit 3 aborts the frame.
        d = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++)
            drive_bit(d[i]);
        bus.serialdata_in = d[3];
        idle(CPB / 2);
        rst = 1'b0;
        idle(2);
        check("midrst_dataout", bus.dataout, 0);
        check("midrst_valid", bus.rx_valid, 0);
        check("midrst_busy", bus.rx_busy, 0);
        check("midrst_frame_err", bus.frame_err, 0);
        check("midrst_parity_err", bus.parity_err, 0);
        check("midrst_overrun_err", bus.overrun_err, 0);
        bus.serialdata_in = 1'b1;
        rst = 1'b1;
        idle(12 * CPB);
        check("midrst_no_delivery", bus.rx_valid, 0);
        check("midrst_idle", bus.rx_busy, 0);
        expect_frame(8'h5A, 1'b1, good_parity(8'h5A, 1'b0));
        idle(10);
        drain("post_reset_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
